csr_pointer_gen: RTL and testbench

Upstream encoder for the pointer buffer. Scans one dense activation tile (ROWS x COLS, row-major stream), drops zeros, writes each nonzero value and its column index to the value/index buffer, and writes the ROWS+1 CSR row pointers into the pointer buffer write port. It signals done once the tile's pointers and values are fully written, so the downstream scheduler can read all pointers in parallel.

---
 rtl/sparse_pkg.sv | 24 ++
 rtl/nz_detect.sv | 25 ++
 rtl/csr_pointer_gen.sv | 216 +++++++++++++++++++++
 tb/tb_csr_pointer_gen.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pkg.sv
// Shared types and default widths for the CSR encoder, pointer buffer and value buffer.
package sparse_pkg;

  localparam int unsigned DefDwidth  = 8;
  localparam int unsigned DefPwidth  = 8;
  localparam int unsigned DefAwidth  = 5;
  localparam int unsigned DefVawidth = 7;
  localparam int unsigned DefRows    = 16;
  localparam int unsigned DefCols    = 8;

  typedef enum logic [2:0] {
    StIdle,
    StP0,
    StScan,
    StFlush,
    StDone
  } csr_state_e;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nz_detect.sv
// Combinational nonzero test for one activation; with CSR_THRESH_EN defined it prunes
// elements whose magnitude does not exceed a signed threshold.
module nz_detect #(
  parameter int unsigned DWIDTH = 8
) (
  input  logic [DWIDTH-1:0] data_i,
`ifdef CSR_THRESH_EN
  input  logic [DWIDTH-1:0] thresh_i,
`endif
  output logic              nz_o
);

`ifdef CSR_THRESH_EN
  logic [DWIDTH:0] mag;

  // Extra bit keeps the magnitude of the most negative value representable.
  always_comb begin
    mag = data_i[DWIDTH-1] ? ({1'b0, ~data_i} + {{DWIDTH{1'b0}}, 1'b1}) : {1'b0, data_i};
    nz_o = thresh_i[DWIDTH-1] ? 1'b1 : (mag > {1'b0, thresh_i});
  end
`else
  assign nz_o = |data_i;
`endif

endmodule

// File: rtl/csr_pointer_gen.sv
// Dense-tile to CSR encoder: streams a ROWS x COLS tile, writes nonzeros/column indices and
// ROWS+1 row pointers. Optional magnitude pruning via macro CSR_THRESH_EN (adds thresh_i).
module csr_pointer_gen
  import sparse_pkg::*;
#(
  parameter int unsigned DWIDTH  = DefDwidth,
  parameter int unsigned PWIDTH  = DefPwidth,
  parameter int unsigned AWIDTH  = DefAwidth,
  parameter int unsigned VAWIDTH = DefVawidth,
  parameter int unsigned ROWS    = DefRows,
  parameter int unsigned COLS    = DefCols,
  localparam int unsigned CWIDTH = cnt_width(COLS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               in_valid_i,
  input  logic [DWIDTH-1:0]  in_data_i,
`ifdef CSR_THRESH_EN
  input  logic [DWIDTH-1:0]  thresh_i,
`endif
  output logic               in_ready_o,
  output logic [AWIDTH-1:0]  ptr_addr_o,
  output logic               ptr_ce_o,
  output logic               ptr_we_o,
  output logic [PWIDTH-1:0]  ptr_d_o,
  output logic               val_we_o,
  output logic [VAWIDTH-1:0] val_addr_o,
  output logic [DWIDTH-1:0]  val_d_o,
  output logic [CWIDTH-1:0]  idx_d_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [PWIDTH-1:0]  nnz_count_o,
  output logic               overflow_o
);

  localparam int unsigned RWIDTH = cnt_width(ROWS);
  localparam logic [PWIDTH-1:0] Cap = PWIDTH'(2 ** VAWIDTH);

  csr_state_e         state_q, state_d;
  logic [RWIDTH-1:0]  row_q, row_d;
  logic [CWIDTH-1:0]  col_q, col_d;
  logic [PWIDTH-1:0]  nnz_q, nnz_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ptr_we_q, ptr_we_d;
  logic [AWIDTH-1:0]  ptr_addr_q, ptr_addr_d;
  logic [PWIDTH-1:0]  ptr_val_q, ptr_val_d;
  logic               val_we_q, val_we_d;
  logic [VAWIDTH-1:0] val_addr_q, val_addr_d;
  logic [DWIDTH-1:0]  val_q, val_d;
  logic [CWIDTH-1:0]  idx_q, idx_d;

  logic accept;
  logic elem_nz;
  logic last_col;
  logic last_row;

`ifdef CSR_THRESH_EN
  logic [DWIDTH-1:0] thresh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q <= '0;
    end else if (state_q == StIdle && start_i) begin
      thresh_q <= thresh_i;
    end
  end
`endif

  nz_detect #(
    .DWIDTH (DWIDTH)
  ) u_nz_detect (
    .data_i   (in_data_i),
`ifdef CSR_THRESH_EN
    .thresh_i (thresh_q),
`endif
    .nz_o     (elem_nz)
  );

  assign accept   = (state_q == StScan) && in_valid_i && in_ready_q;
  assign last_col = (col_q == CWIDTH'(COLS - 1));
  assign last_row = (row_q == RWIDTH'(ROWS - 1));

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    nnz_d      = nnz_q;
    ovf_d      = ovf_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ptr_we_d   = 1'b0;
    ptr_addr_d = ptr_addr_q;
    ptr_val_d  = ptr_val_q;
    val_we_d   = 1'b0;
    val_addr_d = val_addr_q;
    val_d      = val_q;
    idx_d      = idx_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StP0;
          row_d      = '0;
          col_d      = '0;
          nnz_d      = '0;
          ovf_d      = 1'b0;
          busy_d     = 1'b1;
          ptr_we_d   = 1'b1;
          ptr_addr_d = '0;
          ptr_val_d  = '0;
        end
      end
      StP0: begin
        state_d    = StScan;
        in_ready_d = 1'b1;
      end
      StScan: begin
        if (accept) begin
          if (elem_nz) begin
            // Past capacity the value is dropped and the count saturates.
            if (nnz_q < Cap) begin
              val_we_d   = 1'b1;
              val_addr_d = nnz_q[VAWIDTH-1:0];
              val_d      = in_data_i;
              idx_d      = col_q;
              nnz_d      = nnz_q + PWIDTH'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (last_col) begin
            col_d      = '0;
            ptr_we_d   = 1'b1;
            ptr_addr_d = AWIDTH'(row_q) + AWIDTH'(1);
            ptr_val_d  = nnz_d;
            if (last_row) begin
              state_d    = StFlush;
              in_ready_d = 1'b0;
            end else begin
              row_d = row_q + RWIDTH'(1);
            end
          end else begin
            col_d = col_q + CWIDTH'(1);
          end
        end
      end
      StFlush: begin
        state_d = StDone;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      nnz_q      <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ptr_we_q   <= 1'b0;
      ptr_addr_q <= '0;
      ptr_val_q  <= '0;
      val_we_q   <= 1'b0;
      val_addr_q <= '0;
      val_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      nnz_q      <= nnz_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ptr_we_q   <= ptr_we_d;
      ptr_addr_q <= ptr_addr_d;
      ptr_val_q  <= ptr_val_d;
      val_we_q   <= val_we_d;
      val_addr_q <= val_addr_d;
      val_q      <= val_d;
      idx_q      <= idx_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign ptr_addr_o  = ptr_addr_q;
  assign ptr_ce_o    = ptr_we_q;
  assign ptr_we_o    = ptr_we_q;
  assign ptr_d_o     = ptr_val_q;
  assign val_we_o    = val_we_q;
  assign val_addr_o  = val_addr_q;
  assign val_d_o     = val_q;
  assign idx_d_o     = idx_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign nnz_count_o = nnz_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_csr_pointer_gen.sv
// Randomized bench for csr_pointer_gen: two DUTs (value capacity 128 and 64) share stimulus
// and are checked every cycle against a tile-level model of the CSR write stream.
module tb_csr_pointer_gen;

  localparam int NEL  = 128;
  localparam int COLS = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
`ifdef CSR_THRESH_EN
  logic [7:0] thresh;
`endif

  logic       in_ready_a, ptr_ce_a, ptr_we_a, val_we_a, busy_a, done_a, ovf_a;
  logic [4:0] ptr_addr_a;
  logic [7:0] ptr_d_a, val_d_a, nnz_a;
  logic [6:0] val_addr_a;
  logic [2:0] idx_a;

  logic       in_ready_b, ptr_ce_b, ptr_we_b, val_we_b, busy_b, done_b, ovf_b;
  logic [4:0] ptr_addr_b;
  logic [7:0] ptr_d_b, val_d_b, nnz_b;
  logic [5:0] val_addr_b;
  logic [2:0] idx_b;

  always #5 clk = ~clk;

  csr_pointer_gen u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
`ifdef CSR_THRESH_EN
    .thresh_i    (thresh),
`endif
    .in_ready_o  (in_ready_a),
    .ptr_addr_o  (ptr_addr_a),
    .ptr_ce_o    (ptr_ce_a),
    .ptr_we_o    (ptr_we_a),
    .ptr_d_o     (ptr_d_a),
    .val_we_o    (val_we_a),
    .val_addr_o  (val_addr_a),
    .val_d_o     (val_d_a),
    .idx_d_o     (idx_a),
    .busy_o      (busy_a),
    .done_o      (done_a),
    .nnz_count_o (nnz_a),
    .overflow_o  (ovf_a)
  );

  csr_pointer_gen #(
    .VAWIDTH (6)
  ) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
`ifdef CSR_THRESH_EN
    .thresh_i    (thresh),
`endif
    .in_ready_o  (in_ready_b),
    .ptr_addr_o  (ptr_addr_b),
    .ptr_ce_o    (ptr_ce_b),
    .ptr_we_o    (ptr_we_b),
    .ptr_d_o     (ptr_d_b),
    .val_we_o    (val_we_b),
    .val_addr_o  (val_addr_b),
    .val_d_o     (val_d_b),
    .idx_d_o     (idx_b),
    .busy_o      (busy_b),
    .done_o      (done_b),
    .nnz_count_o (nnz_b),
    .overflow_o  (ovf_b)
  );

  int n_tot  = 0;
  int n_pass = 0;

  // Model: phase 0 idle, 1 first pointer, 2 scanning, 3 flush, 4 done.
  int         ph;
  int         m_k;
  int         m_nz;
  int         cap [2] = '{128, 64};
  logic [7:0] thr_s;
  bit         e_ready, e_busy, e_done, e_pwe;
  int         e_paddr, e_vd, e_idx;
  int         e_pd [2];
  bit         e_vwe [2];
  int         e_vaddr [2];
  int         e_nnz [2];
  bit         e_ovf [2];

  logic [7:0] tile [NEL];
  logic [7:0] ptr_mem [2][32];
  logic [7:0] val_mem [128];
  logic [2:0] idx_mem [128];
  int         pw_cnt [2];
  int         vw_cnt [2];
  int         done_cnt [2];

  task automatic cmp(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", nm, d, act, exp, $time);
  endtask

  function automatic bit is_nz(input logic [7:0] x);
`ifdef CSR_THRESH_EN
    int v = int'($signed(x));
    if (v < 0) v = -v;
    return v > int'($signed(thr_s));
`else
    return x != 8'd0;
`endif
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic m_reset();
    ph = 0; m_k = 0; m_nz = 0;
    e_ready = 0; e_busy = 0; e_done = 0; e_pwe = 0; e_paddr = 0; e_vd = 0; e_idx = 0;
    for (int d = 0; d < 2; d++) begin
      e_pd[d] = 0; e_vwe[d] = 0; e_vaddr[d] = 0; e_nnz[d] = 0; e_ovf[d] = 0;
    end
  endtask

  task automatic m_step();
    int row, col;
    bit nz;
    e_pwe = 0; e_done = 0; e_vwe[0] = 0; e_vwe[1] = 0;
    case (ph)
      0: if (start) begin
        ph = 1; m_k = 0; m_nz = 0; e_busy = 1;
        e_pwe = 1; e_paddr = 0;
`ifdef CSR_THRESH_EN
        thr_s = thresh;
`else
        thr_s = 8'd0;
`endif
        for (int d = 0; d < 2; d++) begin
          e_pd[d] = 0; e_nnz[d] = 0; e_ovf[d] = 0;
        end
      end
      1: begin ph = 2; e_ready = 1; end
      2: if (in_valid) begin
        row = m_k / COLS;
        col = m_k % COLS;
        nz  = is_nz(in_data);
        for (int d = 0; d < 2; d++) begin
          if (nz && m_nz < cap[d]) begin
            e_vwe[d] = 1; e_vaddr[d] = m_nz;
          end
        end
        if (nz) begin e_vd = int'(in_data); e_idx = col; end
        m_nz += int'(nz);
        for (int d = 0; d < 2; d++) begin
          e_nnz[d] = min2(m_nz, cap[d]);
          e_ovf[d] = m_nz > cap[d];
          e_pd[d]  = e_nnz[d];
        end
        if (col == COLS - 1) begin e_pwe = 1; e_paddr = row + 1; end
        m_k++;
        if (m_k == NEL) begin ph = 3; e_ready = 0; end
      end
      3: begin ph = 4; e_done = 1; e_busy = 0; end
      4: ph = 0;
      default: ph = 0;
    endcase
  endtask

  task automatic chk_outs(input int d, input bit z, input logic rdy, busy, done, pwe, pce,
                          input logic [31:0] paddr, pd, input logic vwe,
                          input logic [31:0] vaddr, vd, idx, nnz, input logic ovf);
    cmp("in_ready", d, 32'(rdy), z ? 0 : 32'(e_ready));
    cmp("busy", d, 32'(busy), z ? 0 : 32'(e_busy));
    cmp("done", d, 32'(done), z ? 0 : 32'(e_done));
    cmp("ptr_we", d, 32'(pwe), z ? 0 : 32'(e_pwe));
    cmp("ptr_ce", d, 32'(pce), z ? 0 : 32'(e_pwe));
    cmp("val_we", d, 32'(vwe), z ? 0 : 32'(e_vwe[d]));
    cmp("nnz_count", d, nnz, z ? 0 : 32'(e_nnz[d]));
    cmp("overflow", d, 32'(ovf), z ? 0 : 32'(e_ovf[d]));
    if (z || e_pwe) begin
      cmp("ptr_addr", d, paddr, z ? 0 : 32'(e_paddr));
      cmp("ptr_d", d, pd, z ? 0 : 32'(e_pd[d]));
    end
    if (z || e_vwe[d]) begin
      cmp("val_addr", d, vaddr, z ? 0 : 32'(e_vaddr[d]));
      cmp("val_d", d, vd, z ? 0 : 32'(e_vd));
      cmp("idx_d", d, idx, z ? 0 : 32'(e_idx));
    end
  endtask

  task automatic chk_both(input bit z);
    chk_outs(0, z, in_ready_a, busy_a, done_a, ptr_we_a, ptr_ce_a, 32'(ptr_addr_a),
             32'(ptr_d_a), val_we_a, 32'(val_addr_a), 32'(val_d_a), 32'(idx_a), 32'(nnz_a),
             ovf_a);
    chk_outs(1, z, in_ready_b, busy_b, done_b, ptr_we_b, ptr_ce_b, 32'(ptr_addr_b),
             32'(ptr_d_b), val_we_b, 32'(val_addr_b), 32'(val_d_b), 32'(idx_b), 32'(nnz_b),
             ovf_b);
  endtask

  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else m_step();
    #1;
    if (rst_n) begin
      chk_both(1'b0);
      if (ptr_we_a) begin ptr_mem[0][ptr_addr_a] = ptr_d_a; pw_cnt[0]++; end
      if (ptr_we_b) begin ptr_mem[1][ptr_addr_b] = ptr_d_b; pw_cnt[1]++; end
      if (val_we_a) begin val_mem[val_addr_a] = val_d_a; idx_mem[val_addr_a] = idx_a; vw_cnt[0]++; end
      if (val_we_b) vw_cnt[1]++;
      if (done_a) done_cnt[0]++;
      if (done_b) done_cnt[1]++;
    end
  end

  task automatic clear_cap();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) ptr_mem[d][i] = 8'hee;
      pw_cnt[d] = 0; vw_cnt[d] = 0; done_cnt[d] = 0;
    end
  endtask

  // pat: 0 all zero, 1 diagonal, 2 all ones, 3 random. abort_k >= 0 resets after that many accepts.
  task automatic run_tile(input int pat, input int gap, input int abort_k);
    int k, cyc;
    for (int i = 0; i < NEL; i++) begin
      case (pat)
        0: tile[i] = 8'd0;
        1: tile[i] = ((i % COLS) == ((i / COLS) % 8)) ? 8'(i / COLS + 1) : 8'd0;
        2: tile[i] = 8'd1;
        default: tile[i] = ($urandom_range(1) == 0) ? 8'd0 : 8'($urandom_range(255));
      endcase
    end
    clear_cap();
    @(negedge clk);
    start = 1'b1;
`ifdef CSR_THRESH_EN
    thresh = (pat == 3) ? 8'($urandom_range(3)) : 8'd0;
`endif
    @(negedge clk);
    start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < NEL && cyc < 4000) begin
      in_data  = tile[k];
      in_valid = ($urandom_range(99) >= gap);
      start    = ($urandom_range(19) == 0);
      @(posedge clk);
      if (in_valid && in_ready_a) k++;
      if (abort_k >= 0 && k == abort_k) break;
      @(negedge clk);
      cyc++;
    end
    if (abort_k >= 0) begin
      #2 rst_n = 1'b0;
      #1 chk_both(1'b1);
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      cmp("aborted_tile_done", 0, done_cnt[0], 0);
    end else begin
      cmp("elements_accepted", 0, k, NEL);
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      cmp("done_pulses", 0, done_cnt[0], 1);
      cmp("done_pulses", 1, done_cnt[1], 1);
      cmp("ptr_writes", 0, pw_cnt[0], 17);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
`ifdef CSR_THRESH_EN
    thresh = 8'd0;
`endif
    thr_s = 8'd0;
    m_reset();
    clear_cap();
    #3 chk_both(1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_tile(0, 0, -1);
    cmp("zero_ptr16", 0, 32'(ptr_mem[0][16]), 0);
    cmp("zero_ptr0", 0, 32'(ptr_mem[0][0]), 0);
    cmp("zero_vals", 0, vw_cnt[0], 0);
    cmp("zero_nnz", 0, 32'(nnz_a), 0);

    run_tile(1, 0, -1);
    cmp("diag_ptr5", 0, 32'(ptr_mem[0][5]), 5);
    cmp("diag_ptr16", 0, 32'(ptr_mem[0][16]), 16);
    cmp("diag_vals", 0, vw_cnt[0], 16);
    cmp("diag_val3", 0, 32'(val_mem[3]), 4);
    cmp("diag_idx3", 0, 32'(idx_mem[3]), 3);
    cmp("diag_val15", 0, 32'(val_mem[15]), 16);
    cmp("diag_idx15", 0, 32'(idx_mem[15]), 7);

    run_tile(2, 0, -1);
    cmp("dense_ptr3", 0, 32'(ptr_mem[0][3]), 24);
    cmp("dense_ptr16", 0, 32'(ptr_mem[0][16]), 128);
    cmp("dense_vals", 0, vw_cnt[0], 128);
    cmp("dense_ovf", 0, 32'(ovf_a), 0);
    cmp("cap64_ptr7", 1, 32'(ptr_mem[1][7]), 56);
    cmp("cap64_ptr8", 1, 32'(ptr_mem[1][8]), 64);
    cmp("cap64_ptr16", 1, 32'(ptr_mem[1][16]), 64);
    cmp("cap64_vals", 1, vw_cnt[1], 64);
    cmp("cap64_nnz", 1, 32'(nnz_b), 64);
    cmp("cap64_ovf", 1, 32'(ovf_b), 1);

    run_tile(2, 50, -1);
    cmp("gap_ptr16", 0, 32'(ptr_mem[0][16]), 128);

    run_tile(3, 30, 43);
    run_tile(0, 0, -1);
    cmp("after_abort_ptr16", 0, 32'(ptr_mem[0][16]), 0);
    cmp("after_abort_ptr5", 0, 32'(ptr_mem[0][5]), 0);

    for (int t = 0; t < 4; t++) run_tile(3, $urandom_range(60), -1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
